aes_stream_loader: RTL



---
 rtl/aes_stream_loader_if.sv | 36 +++
 rtl/aes_stream_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/aes_stream_loader_if.sv
// Bus bundle between aes_stream_loader and its environment: word streams in/out, key load and cipher-core link.
// The slave modport is the loader's view; master is the surrounding logic (streams + AES core).
interface aes_stream_loader_if;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               key_valid;
    logic               key_ready;
    logic [BLOCK_W-1:0] key_in;
    logic               aes_ld;
    logic [BLOCK_W-1:0] aes_key;
    logic [BLOCK_W-1:0] aes_text_in;
    logic               aes_done;
    logic [BLOCK_W-1:0] aes_text_out;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_data;
    logic               out_last;
    logic               busy;
    logic               timeout_err;

    modport slave (
        input  in_valid, in_data, key_valid, key_in, aes_done, aes_text_out, out_ready,
        output in_ready, key_ready, aes_ld, aes_key, aes_text_in, out_valid, out_data,
        output out_last, busy, timeout_err
    );

    modport master (
        output in_valid, in_data, key_valid, key_in, aes_done, aes_text_out, out_ready,
        input  in_ready, key_ready, aes_ld, aes_key, aes_text_in, out_valid, out_data,
        input  out_last, busy, timeout_err
    );
endinterface

// File: rtl/aes_stream_loader.sv
// Wraps the iterative AES-128 core: gathers 4 input words into a block, loads the core, streams the result out.
// Optional WAIT watchdog enabled by defining AES_STREAM_TIMEOUT_EN.
module aes_stream_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 31,
    parameter int unsigned TO_CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    aes_stream_loader_if.slave bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    // Counter must be able to reach TIMEOUT_CYCLES-1 without wrapping
    if (((64'd1 << TO_CNT_W) <= 64'(TIMEOUT_CYCLES)) || (TIMEOUT_CYCLES == 0)) begin : g_bad_cfg
        $error("aes_stream_loader: TO_CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [BLOCK_W-1:0] text_q, text_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] result_q, result_d;

`ifdef AES_STREAM_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                terr_q, terr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            terr_q   <= terr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_COLLECT;
            cnt_q    <= '0;
            text_q   <= '0;
            key_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            text_q   <= text_d;
            key_q    <= key_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        text_d   = text_q;
        key_d    = key_q;
        result_d = result_q;
`ifdef AES_STREAM_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        terr_d   = 1'b0;
`endif
        unique case (state_q)
            ST_COLLECT: begin
                // A key arriving alongside the 4th word still applies to this block
                if (bus.key_valid) begin
                    key_d = bus.key_in;
                end
                if (bus.in_valid) begin
                    text_d = {text_q[BLOCK_W-WORD_W-1:0], bus.in_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.aes_done) begin
                    result_d = bus.aes_text_out;
                    state_d  = ST_DRAIN;
`ifdef AES_STREAM_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_cnt_d = '0;
                    terr_d   = 1'b1;
                    state_d  = ST_COLLECT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_CNT_W'(1);
`endif
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    result_d = {result_q[BLOCK_W-WORD_W-1:0], WORD_W'(0)};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // Handshake outputs decode state/registers only; no input-to-ready paths
    assign bus.in_ready    = (state_q == ST_COLLECT);
    assign bus.key_ready   = (state_q == ST_COLLECT);
    assign bus.aes_ld      = (state_q == ST_LOAD);
    assign bus.aes_key     = key_q;
    assign bus.aes_text_in = text_q;
    assign bus.out_valid   = (state_q == ST_DRAIN);
    assign bus.out_data    = result_q[BLOCK_W-1 -: WORD_W];
    assign bus.out_last    = (state_q == ST_DRAIN) && (cnt_q == 2'd3);
    assign bus.busy        = (state_q != ST_COLLECT);
`ifdef AES_STREAM_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule
